// File: rtl/comar_mask_gen.sv
// Fresh-mask source for COMAR 2-share gadgets: a 32-bit LFSR stepped 7 bits at a time,
// seeded over a valid/ready handshake, with a warm-up period before masks are flagged valid.
module comar_mask_gen #(
    parameter int WARMUP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        seed_valid,
    output logic        seed_ready,
    output logic        seed_err,
    input  logic        en,
    input  logic        common_refresh,
    output logic [5:0]  r,
    output logic        common_out,
    output logic        mask_valid
);

    // Seed handshake: a seed transfers on a rising edge where seed_valid && seed_ready;
    // seed_valid may be held without ready, and seed_ready does not depend on seed_valid.
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

    state_t        state, state_nx;
    logic [31:0]   lfsr, lfsr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [5:0]    r_nx;
    logic          common_nx, seed_ready_nx, seed_err_nx, mask_valid_nx;
    logic          hs, seed_ok;
    logic [38:0]   step;
    logic [31:0]   step_s;
    logic [6:0]    step_b;

    // Seven serial shifts of x^32+x^22+x^2+x+1; returns {feedback bits, new state}.
    function automatic logic [38:0] step_f(input logic [31:0] s_in);
        logic [31:0] s;
        logic [6:0]  b;
        logic        fb;
        s = s_in;
        b = '0;
        for (int k = 0; k < 7; k++) begin
            fb   = s[31] ^ s[21] ^ s[1] ^ s[0];
            b[k] = fb;
            s    = {s[30:0], fb};
        end
        return {b, s};
    endfunction

    assign step    = step_f(lfsr);
    assign step_s  = step[31:0];
    assign step_b  = step[38:32];
    assign hs      = seed_valid & seed_ready;
    assign seed_ok = (seed != 32'h0);

    always_comb begin
        state_nx    = state;
        lfsr_nx     = lfsr;
        cnt_nx      = cnt;
        r_nx        = r;
        common_nx   = common_out;
        seed_err_nx = hs & ~seed_ok;
        case (state)
            ST_IDLE: begin
                if (hs && seed_ok) begin
                    lfsr_nx  = seed;
                    cnt_nx   = '0;
                    state_nx = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                lfsr_nx = step_s;
                r_nx    = step_b[5:0];
                cnt_nx  = cnt + 1'b1;
                if (cnt == CW'(WARMUP - 1)) begin
                    common_nx = step_b[6];
                    cnt_nx    = '0;
                    state_nx  = ST_RUN;
                end
            end
            ST_RUN: begin
                // A reseed takes priority over en in the same cycle.
                if (hs && seed_ok) begin
                    lfsr_nx  = seed;
                    cnt_nx   = '0;
                    state_nx = ST_WARMUP;
                end else if (en) begin
                    lfsr_nx = step_s;
                    r_nx    = step_b[5:0];
                    if (common_refresh) begin
                        common_nx = step_b[6];
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        seed_ready_nx = (state_nx != ST_WARMUP);
        mask_valid_nx = (state == ST_RUN) && (state_nx == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lfsr       <= '0;
            cnt        <= '0;
            r          <= '0;
            common_out <= 1'b0;
            mask_valid <= 1'b0;
            seed_ready <= 1'b0;
            seed_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            cnt        <= cnt_nx;
            r          <= r_nx;
            common_out <= common_nx;
            mask_valid <= mask_valid_nx;
            seed_ready <= seed_ready_nx;
            seed_err   <= seed_err_nx;
        end
    end

endmodule

// File: tb/tb_comar_mask_gen.sv
// Directed bench for comar_mask_gen: reset, seed rejection, warm-up timing, mask stream
// against a reference step model, en gating, reseed and asynchronous reset mid-warm-up.
module tb_comar_mask_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seed = '0;
    logic        seed_valid = 1'b0;
    logic        seed_ready;
    logic        seed_err;
    logic        en = 1'b0;
    logic        common_refresh = 1'b0;
    logic [5:0]  r;
    logic        common_out;
    logic        mask_valid;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_lfsr;
    logic [5:0]  m_r;
    logic        m_c;
    logic [6:0]  exp_q[$];

    comar_mask_gen #(.WARMUP(32)) dut (
        .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .seed_err(seed_err), .en(en),
        .common_refresh(common_refresh), .r(r), .common_out(common_out),
        .mask_valid(mask_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: b[k] is the feedback of shift k, s shifts left taking it in.
    task automatic m_step(output logic [6:0] b);
        logic fb;
        b = '0;
        for (int k = 0; k < 7; k++) begin
            fb     = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
            b[k]   = fb;
            m_lfsr = {m_lfsr[30:0], fb};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a seed, then follows the warm-up until mask_valid rises.
    task automatic seed_and_warmup(input logic [31:0] sd);
        logic [6:0] b;
        int n;
        seed = sd;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        en = 1'b0;
        common_refresh = 1'b0;
        n_checks++;
        if (mask_valid !== 1'b0) begin n_fail++; $display("FAIL accept_mask_valid: got %b expected 0", mask_valid); end
        n_checks++;
        if (seed_ready !== 1'b0) begin n_fail++; $display("FAIL accept_seed_ready: got %b expected 0", seed_ready); end
        m_lfsr = sd;
        b = '0;
        for (int i = 0; i < 32; i++) m_step(b);
        m_r = b[5:0];
        m_c = b[6];
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (i <= 31) begin
                n_checks++;
                if (seed_ready !== 1'b0) begin n_fail++; $display("FAIL warmup_seed_ready: cycle %0d got %b expected 0", i, seed_ready); end
            end
            if (mask_valid === 1'b1) break;
        end
        n_checks++;
        if (n != 33) begin n_fail++; $display("FAIL warmup_latency: got %0d cycles expected 33", n); end
        n_checks++;
        if (r !== m_r) begin n_fail++; $display("FAIL warmup_r: got %h expected %h", r, m_r); end
        n_checks++;
        if (common_out !== m_c) begin n_fail++; $display("FAIL warmup_common: got %b expected %b", common_out, m_c); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({r, common_out, mask_valid, seed_ready, seed_err} !== 10'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 0", {r, common_out, mask_valid, seed_ready, seed_err});
        end
        rst_n = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (seed_ready !== 1'b1) begin n_fail++; $display("FAIL idle_seed_ready: got %b expected 1", seed_ready); end
        n_checks++;
        if ({r, common_out, mask_valid, seed_err} !== 9'h0) begin
            n_fail++; $display("FAIL idle_outputs: got %b expected 0", {r, common_out, mask_valid, seed_err});
        end
    endtask

    task automatic test_zero_seed();
        seed = 32'h0;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (seed_err !== 1'b1) begin n_fail++; $display("FAIL zero_seed_err: got %b expected 1", seed_err); end
        n_checks++;
        if (seed_ready !== 1'b1) begin n_fail++; $display("FAIL zero_seed_ready: got %b expected 1", seed_ready); end
        tick();
        n_checks++;
        if (seed_err !== 1'b0) begin n_fail++; $display("FAIL zero_seed_err_pulse: got %b expected 0", seed_err); end
        n_checks++;
        if (mask_valid !== 1'b0) begin n_fail++; $display("FAIL zero_seed_mask_valid: got %b expected 0", mask_valid); end
    endtask

    task automatic test_seed_one_stream();
        logic [6:0] b;
        seed_and_warmup(32'h0000_0001);
        for (int i = 0; i < 1000; i++) begin
            en = 1'b1;
            common_refresh = (i % 4 == 0);
            tick();
            m_step(b);
            m_r = b[5:0];
            if (common_refresh) m_c = b[6];
            n_checks++;
            if (r !== m_r) begin n_fail++; $display("FAIL stream_r: step %0d got %h expected %h", i, r, m_r); end
            n_checks++;
            if (common_out !== m_c) begin n_fail++; $display("FAIL stream_common: step %0d got %b expected %b", i, common_out, m_c); end
        end
        en = 1'b0;
        common_refresh = 1'b0;
    endtask

    task automatic test_en_gating();
        logic [31:0] pat;
        logic [6:0] b;
        pat = 32'hB3C5_96E1;
        for (int i = 0; i < 200; i++) begin
            en = pat[i % 32];
            common_refresh = (i % 10 == 7);
            seed = 32'h0;
            seed_valid = (i == 50);
            tick();
            seed_valid = 1'b0;
            if (en) begin
                m_step(b);
                m_r = b[5:0];
                if (common_refresh) m_c = b[6];
            end
            n_checks++;
            if (r !== m_r) begin n_fail++; $display("FAIL gate_r: cycle %0d got %h expected %h", i, r, m_r); end
            n_checks++;
            if (common_out !== m_c) begin n_fail++; $display("FAIL gate_common: cycle %0d got %b expected %b", i, common_out, m_c); end
            n_checks++;
            if (mask_valid !== 1'b1) begin n_fail++; $display("FAIL gate_mask_valid: cycle %0d got %b expected 1", i, mask_valid); end
            n_checks++;
            if (seed_err !== (i == 50)) begin n_fail++; $display("FAIL gate_seed_err: cycle %0d got %b expected %b", i, seed_err, (i == 50)); end
        end
        en = 1'b0;
        common_refresh = 1'b0;
    endtask

    task automatic test_reseed();
        logic [6:0] b;
        en = 1'b1;
        common_refresh = 1'b1;
        seed_and_warmup(32'hDEAD_BEEF);
        for (int i = 0; i < 20; i++) begin
            en = 1'b1;
            common_refresh = (i % 3 == 0);
            tick();
            m_step(b);
            m_r = b[5:0];
            if (common_refresh) m_c = b[6];
            n_checks++;
            if ({common_out, r} !== {m_c, m_r}) begin
                n_fail++; $display("FAIL reseed_stream: step %0d got %h expected %h", i, {common_out, r}, {m_c, m_r});
            end
            exp_q.push_back({m_c, m_r});
        end
        en = 1'b0;
        common_refresh = 1'b0;
    endtask

    task automatic test_async_reset_and_replay();
        logic [6:0] e;
        seed = 32'hDEAD_BEEF;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({r, common_out, mask_valid, seed_ready, seed_err} !== 10'h0) begin
            n_fail++; $display("FAIL async_reset_outputs: got %b expected 0", {r, common_out, mask_valid, seed_ready, seed_err});
        end
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (seed_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_seed_ready: got %b expected 1", seed_ready); end
        n_checks++;
        if (mask_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_mask_valid: got %b expected 0", mask_valid); end
        seed_and_warmup(32'hDEAD_BEEF);
        for (int i = 0; i < 20; i++) begin
            en = 1'b1;
            common_refresh = (i % 3 == 0);
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7F;
            n_checks++;
            if ({common_out, r} !== e) begin
                n_fail++; $display("FAIL replay_stream: step %0d got %h expected %h", i, {common_out, r}, e);
            end
        end
        en = 1'b0;
        common_refresh = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_seed();
        test_seed_one_stream();
        test_en_gating();
        test_reseed();
        test_async_reset_and_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
